riscv_multicycle_core: RTL and testbench

- Parametrised multicycle RISC-V integer core: FSM-sequenced fetch/decode/execute/memory/writeback.
- One shared ALU, internal IR, A, B and ALUOut registers, internal register file.
- Separate instruction and data memory ports, each with a req/ack handshake that tolerates arbitrary wait states.
- Generalises the fixed-width, control-less datapath to XLEN 32/64, RV-I/RV-E register counts and a programmable reset vector.

---
 rtl/riscv_multicycle_core.sv | 249 ++++++++++++++++++++++++
 tb/tb_riscv_multicycle_core.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_core.sv
// Multicycle RV64I/RV32I (or RV-E) integer core subset.
// A single FSM sequences fetch/decode/execute/memory/writeback around one
// shared ALU and the IR/A/B/ALUOut staging registers.
// Instruction and data ports use req/ack handshakes with arbitrary wait states.
module riscv_multicycle_core #(
    parameter int              XLEN     = 64,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            halted,
    output logic [XLEN-1:0] pc_out
);

    localparam int         RW    = $clog2(NREG);
    localparam int         AB    = (XLEN == 64) ? 3 : 2;
    localparam logic [2:0] LS_F3 = (XLEN == 64) ? 3'b011 : 3'b010;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;

    typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;

    state_t          state;
    logic [XLEN-1:0] pc, a, b, alu_out;
    logic [31:0]     ir;
    logic [XLEN-1:0] regs [NREG];

    // Instruction fields
    logic [6:0]      opcode, funct7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rs1_val, rs2_val, pc_plus4, next_pc;
    logic [XLEN-1:0] alu_a, alu_b, alu_res;
    alu_op_t         alu_op;
    logic            legal, br_taken, ls_misaligned;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    // Size casts of signed values sign-extend to XLEN
    assign imm_i = XLEN'($signed(ir[31:20]));
    assign imm_s = XLEN'($signed({ir[31:25], ir[11:7]}));
    assign imm_b = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({ir[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));

    assign rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1[RW-1:0]];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2[RW-1:0]];
    assign pc_plus4 = pc + XLEN'(4);
    assign br_taken = (a == b) ^ funct3[0];

    assign imem_addr = pc;
    assign pc_out    = pc;

    // Register index is valid for this register-file size (RV-E has 16)
    function automatic logic reg_ok(input logic [4:0] r);
        return (NREG == 32) || !r[4];
    endfunction

    // Decode legality: opcode/funct match plus in-range register indices
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R:    legal = (((funct7 == 7'h00) && (funct3 == 3'd0 || funct3 == 3'd6 || funct3 == 3'd7)) ||
                              ((funct7 == 7'h20) && (funct3 == 3'd0))) &&
                             reg_ok(rs1) && reg_ok(rs2) && reg_ok(rd);
            OP_IMM:  legal = (funct3 == 3'd0) && reg_ok(rs1) && reg_ok(rd);
            OP_LUI:  legal = reg_ok(rd);
            OP_JAL:  legal = reg_ok(rd);
            OP_BR:   legal = (funct3 == 3'd0 || funct3 == 3'd1) && reg_ok(rs1) && reg_ok(rs2);
            OP_LOAD: legal = (funct3 == LS_F3) && reg_ok(rs1) && reg_ok(rd);
            OP_STOR: legal = (funct3 == LS_F3) && reg_ok(rs1) && reg_ok(rs2);
            default: legal = 1'b0;
        endcase
    end

    // Shared ALU: branch target in DECODE, per-instruction operation in EXEC
    always_comb begin
        alu_a  = a;
        alu_b  = b;
        alu_op = ALU_ADD;
        if (state == S_DECODE) begin
            alu_a = pc;
            alu_b = imm_b;
        end else begin
            case (opcode)
                OP_R: begin
                    if (funct3 == 3'd7)      alu_op = ALU_AND;
                    else if (funct3 == 3'd6) alu_op = ALU_OR;
                    else if (funct7[5])      alu_op = ALU_SUB;
                    else                     alu_op = ALU_ADD;
                end
                OP_IMM, OP_LOAD: alu_b = imm_i;
                OP_STOR:         alu_b = imm_s;
                OP_LUI: begin
                    alu_a = '0;
                    alu_b = imm_u;
                end
                OP_JAL: begin
                    alu_a = pc;
                    alu_b = imm_j;
                end
                default: ;
            endcase
        end
        case (alu_op)
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            default: alu_res = alu_a + alu_b;
        endcase
    end

    assign ls_misaligned = (alu_res[AB-1:0] != '0);

    // Control-transfer target chosen in EXEC
    always_comb begin
        next_pc = pc_plus4;
        if (opcode == OP_BR && br_taken) next_pc = alu_out;
        else if (opcode == OP_JAL)       next_pc = alu_res;
    end

    // Sequencer: state, architectural registers and registered port outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_RST;
            pc         <= RESET_PC;
            ir         <= '0;
            a          <= '0;
            b          <= '0;
            alu_out    <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            halted     <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_RST: begin
                    state    <= S_FETCH;
                    imem_req <= (RESET_PC[1:0] == 2'b00);
                end
                S_FETCH: begin
                    if (pc[1:0] != 2'b00) begin
                        state    <= S_HALT;
                        halted   <= 1'b1;
                        imem_req <= 1'b0;
                    end else if (imem_req && imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a       <= rs1_val;
                    b       <= rs2_val;
                    alu_out <= alu_res;
                    if (legal) begin
                        state <= S_EXEC;
                    end else begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_R, OP_IMM, OP_LUI: begin
                            alu_out <= alu_res;
                            state   <= S_WB;
                        end
                        OP_LOAD, OP_STOR: begin
                            alu_out <= alu_res;
                            if (ls_misaligned) begin
                                state  <= S_HALT;
                                halted <= 1'b1;
                            end else begin
                                dmem_req   <= 1'b1;
                                dmem_we    <= (opcode == OP_STOR);
                                dmem_addr  <= alu_res;
                                dmem_wdata <= b;
                                state      <= S_MEM;
                            end
                        end
                        OP_BR, OP_JAL: begin
                            if (opcode == OP_JAL && rd != 5'd0) regs[rd[RW-1:0]] <= pc_plus4;
                            pc       <= next_pc;
                            imem_req <= (next_pc[1:0] == 2'b00);
                            state    <= S_FETCH;
                        end
                        default: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_req && dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (opcode == OP_LOAD) begin
                            alu_out <= dmem_rdata;
                            state   <= S_WB;
                        end else begin
                            pc       <= pc_plus4;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (rd != 5'd0) regs[rd[RW-1:0]] <= alu_out;
                    pc       <= pc_plus4;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Bench for riscv_multicycle_core: instruction/data memory responders with
// programmable wait states, a store/CPI scoreboard and an RV-E side instance.
module tb_riscv_multicycle_core;

    localparam logic [63:0] RPC    = 64'h40;
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
    logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc_out;
    logic [31:0] imem_rdata;

    // RV-E (NREG=16), XLEN=32 side instance
    logic        e_imem_req, e_imem_ack, e_dmem_req, e_dmem_we, e_dmem_ack, e_halted;
    logic [31:0] e_imem_addr, e_dmem_addr, e_dmem_wdata, e_dmem_rdata, e_pc_out, e_imem_rdata;

    always #5 clock = ~clock;

    riscv_multicycle_core #(.XLEN(64), .NREG(32), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .halted(halted), .pc_out(pc_out)
    );

    riscv_multicycle_core #(.XLEN(32), .NREG(16), .RESET_PC(32'h0)) dut_e (
        .clock(clock), .reset(reset),
        .imem_req(e_imem_req), .imem_addr(e_imem_addr), .imem_ack(e_imem_ack), .imem_rdata(e_imem_rdata),
        .dmem_req(e_dmem_req), .dmem_we(e_dmem_we), .dmem_addr(e_dmem_addr), .dmem_wdata(e_dmem_wdata),
        .dmem_ack(e_dmem_ack), .dmem_rdata(e_dmem_rdata), .halted(e_halted), .pc_out(e_pc_out)
    );

    // ADDI x20,x0,1 forever: x20 does not exist on RV-E
    assign e_imem_rdata = 32'h00100A13;
    assign e_imem_ack   = e_imem_req;
    assign e_dmem_ack   = 1'b0;
    assign e_dmem_rdata = '0;

    int n_chk = 0, n_err = 0;
    int cyc = 0, iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    int fetches = 0, dtx = 0, dreq_hi = 0, e_dreq_hi = 0, last_ack = 0;
    bit have_last = 0, have_iaddr = 0, have_daddr = 0;
    logic [63:0] held_iaddr, held_daddr;
    logic [31:0] prog [256];
    logic [63:0] dm [256];
    logic [63:0] exp_addr_q[$], exp_data_q[$];
    int          exp_cpi_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Standard RV encodings
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        logic [11:0] im = 12'(imm);
        return {im, 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_sd(int imm, int rs2, int rs1);
        logic [11:0] im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b011, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [12:0] im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [20:0] im = 21'(imm);
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6f};
    endfunction

    always @(posedge clock) cyc++;

    // Instruction memory responder: ack after iwait waiting cycles
    always @(negedge clock) begin
        if (reset || !imem_req) begin
            imem_ack = 1'b0; icnt = 0; have_iaddr = 0;
        end else begin
            if (have_iaddr) chk("imem_addr_stable", imem_addr, held_iaddr);
            held_iaddr = imem_addr; have_iaddr = 1;
            if (icnt == iwait) begin
                imem_ack = 1'b1; imem_rdata = prog[imem_addr[9:2]];
                icnt = 0; have_iaddr = 0; fetches++;
                if (have_last && exp_cpi_q.size() > 0) chk("cpi", 64'(cyc - last_ack), 64'(exp_cpi_q.pop_front()));
                last_ack = cyc; have_last = 1;
            end else begin
                imem_ack = 1'b0; icnt++;
            end
        end
    end

    // Data memory responder and store scoreboard
    always @(negedge clock) begin
        if (e_dmem_req) e_dreq_hi++;
        if (reset || !dmem_req) begin
            dmem_ack = 1'b0; dcnt = 0; have_daddr = 0;
        end else begin
            dreq_hi++;
            if (have_daddr) chk("dmem_addr_stable", dmem_addr, held_daddr);
            held_daddr = dmem_addr; have_daddr = 1;
            if (dcnt == dwait) begin
                dmem_ack = 1'b1; dcnt = 0; have_daddr = 0; dtx++;
                if (dmem_we) begin
                    chk("store_expected", 64'(exp_addr_q.size() > 0), 64'd1);
                    if (exp_addr_q.size() > 0) begin
                        chk("store_addr", dmem_addr, exp_addr_q.pop_front());
                        chk("store_data", dmem_wdata, exp_data_q.pop_front());
                    end
                    dm[dmem_addr[10:3]] = dmem_wdata;
                end else begin
                    dmem_rdata = dm[dmem_addr[10:3]];
                end
            end else begin
                dmem_ack = 1'b0; dcnt++;
            end
        end
    end

    task automatic clear_sb();
        exp_addr_q.delete(); exp_data_q.delete(); exp_cpi_q.delete();
        fetches = 0; dtx = 0; dreq_hi = 0; have_last = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_sb();
        repeat (2) @(negedge clock);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc_out", pc_out, RPC);
        chk("rst_imem_addr", imem_addr, RPC);
        reset = 1'b0;
    endtask

    task automatic st(input logic [63:0] addr, input logic [63:0] data);
        exp_addr_q.push_back(addr); exp_data_q.push_back(data);
    endtask

    task automatic run_check(input logic [63:0] halt_pc, input int n_fetch, input int n_dtx);
        for (int i = 0; i < 2000 && !halted; i++) @(negedge clock);
        chk("halt_reached", halted, 1);
        chk("halt_pc", pc_out, halt_pc);
        chk("fetch_count", 64'(fetches), 64'(n_fetch));
        chk("dmem_tx_count", 64'(dtx), 64'(n_dtx));
        chk("stores_pending", 64'(exp_addr_q.size()), 0);
        chk("cpi_pending", 64'(exp_cpi_q.size()), 0);
        repeat (3) @(negedge clock);
        chk("halt_no_ireq", imem_req, 0);
        chk("halt_no_dreq", dmem_req, 0);
        chk("halt_pc_hold", pc_out, halt_pc);
    endtask

    task automatic load_prog_a();
        for (int i = 0; i < 256; i++) prog[i] = '0;
        prog[8'h10] = enc_i(5, 0, 0, 1, 7'h13);      // 40 ADDI x1,x0,5
        prog[8'h11] = enc_i(-3, 0, 0, 2, 7'h13);     // 44 ADDI x2,x0,-3
        prog[8'h12] = enc_r(0, 2, 1, 0, 3);          // 48 ADD x3,x1,x2
        prog[8'h13] = enc_sd(12'h100, 3, 0);         // 4c SD x3,0x100
        prog[8'h14] = {20'h80000, 5'd4, 7'h37};      // 50 LUI x4,0x80000
        prog[8'h15] = enc_sd(12'h108, 4, 0);         // 54 SD x4
        prog[8'h16] = enc_r(7'h20, 2, 1, 0, 5);      // 58 SUB x5,x1,x2
        prog[8'h17] = enc_sd(12'h110, 5, 0);         // 5c
        prog[8'h18] = enc_r(0, 2, 1, 7, 6);          // 60 AND x6
        prog[8'h19] = enc_sd(12'h118, 6, 0);         // 64
        prog[8'h1a] = enc_r(0, 2, 1, 6, 7);          // 68 OR x7
        prog[8'h1b] = enc_sd(12'h120, 7, 0);         // 6c
        prog[8'h1c] = enc_i(12'h100, 0, 3, 8, 7'h03); // 70 LD x8,0x100
        prog[8'h1d] = enc_sd(12'h128, 8, 0);         // 74
        prog[8'h1e] = enc_j(8, 9);                   // 78 JAL x9,+8
        prog[8'h1f] = EBREAK;                        // 7c skipped
        prog[8'h20] = enc_sd(12'h130, 9, 0);         // 80 SD x9
        prog[8'h21] = enc_i(7, 0, 0, 0, 7'h13);      // 84 ADDI x0,x0,7
        prog[8'h22] = enc_sd(12'h080, 0, 0);         // 88 SD x0,0x80
        prog[8'h23] = EBREAK;                        // 8c
    endtask

    task automatic push_a(input int iw, input int dw);
        int cpi_a[18] = '{4,4,4,4,4,4,4,4,4,4,4,4,5,4,3,4,4,4};
        bit mem_a[18] = '{0,0,0,1,0,1,0,1,0,1,0,1,1,1,0,1,0,1};
        for (int i = 0; i < 18; i++) exp_cpi_q.push_back(cpi_a[i] + iw + (mem_a[i] ? dw : 0));
        st(64'h100, 64'd2);
        st(64'h108, 64'hFFFF_FFFF_8000_0000);
        st(64'h110, 64'd8);
        st(64'h118, 64'd5);
        st(64'h120, 64'hFFFF_FFFF_FFFF_FFFD);
        st(64'h128, 64'd2);
        st(64'h130, 64'h7c);
        st(64'h080, 64'd0);
    endtask

    task automatic load_prog_c();
        for (int i = 0; i < 256; i++) prog[i] = '0;
        prog[8'h10] = enc_i(3, 0, 0, 1, 7'h13);      // 40 ADDI x1,x0,3
        prog[8'h11] = enc_i(-1, 1, 0, 1, 7'h13);     // 44 ADDI x1,x1,-1
        prog[8'h12] = enc_b(-4, 0, 1, 1);            // 48 BNE x1,x0,-4
        prog[8'h13] = enc_sd(12'h100, 1, 0);         // 4c SD x1,0x100
        prog[8'h14] = enc_b(8, 0, 0, 0);             // 50 BEQ x0,x0,+8
        prog[8'h15] = EBREAK;                        // 54 skipped
        prog[8'h16] = enc_b(8, 0, 0, 1);             // 58 BNE x0,x0 (not taken)
        prog[8'h17] = EBREAK;                        // 5c
    endtask

    task automatic push_c();
        int cpi_c[10] = '{4,4,3,4,3,4,3,4,3,3};
        foreach (cpi_c[i]) exp_cpi_q.push_back(cpi_c[i]);
        st(64'h100, 64'd0);
    endtask

    initial begin
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
        for (int i = 0; i < 256; i++) dm[i] = '0;

        // Straight-line ALU/LUI/LD/SD/JAL program, zero wait
        load_prog_a();
        do_reset();
        push_a(0, 0);
        run_check(64'h8c, 19, 9);

        // Same program with instruction and data wait states
        iwait = 3; dwait = 2;
        do_reset();
        push_a(3, 2);
        run_check(64'h8c, 19, 9);

        // Branch loop
        iwait = 0; dwait = 0;
        load_prog_c();
        do_reset();
        push_c();
        run_check(64'h5c, 11, 1);

        // Misaligned LD halts without a data request
        for (int i = 0; i < 256; i++) prog[i] = '0;
        prog[8'h10] = enc_i(4, 0, 3, 5, 7'h03);      // LD x5,4(x0)
        do_reset();
        run_check(64'h40, 1, 0);
        chk("ld_misalign_no_dreq", 64'(dreq_hi), 0);

        // Reset while a fetch is waiting
        load_prog_c();
        iwait = 20;
        do_reset();
        repeat (3) @(negedge clock);
        chk("fetch_waiting_req", imem_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_drop_req", imem_req, 0);
        chk("async_rst_pc", pc_out, RPC);
        @(negedge clock);
        iwait = 0;
        reset = 1'b0;
        clear_sb();
        push_c();
        chk("rst_release_no_req", imem_req, 0);
        @(negedge clock);
        chk("refetch_req", imem_req, 1);
        chk("refetch_addr", imem_addr, RPC);
        run_check(64'h5c, 11, 1);

        // RV-E instance: x20 is out of range
        chk("rve_halted", e_halted, 1);
        chk("rve_halt_pc", 64'(e_pc_out), 0);
        chk("rve_no_dreq", 64'(e_dreq_hi), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
